// File: rtl/seg_pkg.sv
// seg_pkg: segment patterns, scan select codes, BCD markers and FSM state type
package seg_pkg;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h67;
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [3:0] SEL_D1 = 4'b0111;
  localparam logic [3:0] SEL_D2 = 4'b1011;
  localparam logic [3:0] SEL_D3 = 4'b1101;
  localparam logic [3:0] SEL_D4 = 4'b1110;
  localparam logic [3:0] SEL_IDLE = 4'hF;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_BAD = 4'hE;
  typedef enum logic {ST_SYNC, ST_RUN} state_t;
endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: combinational 7-segment pattern to BCD decode with blank/bad flags
module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic [3:0] o_code,
  output logic       o_blank,
  output logic       o_bad
);
  always_comb begin
    o_code = BCD_BAD;
    o_blank = 1'b0;
    o_bad = 1'b0;
    case (i_pat)
      SEG_0: o_code = 4'd0;
      SEG_1: o_code = 4'd1;
      SEG_2: o_code = 4'd2;
      SEG_3: o_code = 4'd3;
      SEG_4: o_code = 4'd4;
      SEG_5: o_code = 4'd5;
      SEG_6: o_code = 4'd6;
      SEG_7: o_code = 4'd7;
      SEG_8: o_code = 4'd8;
      SEG_9: o_code = 4'd9;
      SEG_OFF: begin
        o_code = BCD_BLANK;
        o_blank = 1'b1;
      end
      default: o_bad = 1'b1;
    endcase
  end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers 4-digit frames from a multiplexed 7-segment scan
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter logic [15:0] MIN_DWELL = 16'd1000
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [3:0]  seg_sel,
  input  logic [7:0]  seg_dat,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic        frame_valid,
  output logic        code_err,
  output logic        seq_err
);
  logic [3:0] r_sel_q;
  logic [7:0] r_dat_q;
  logic [15:0] r_dwell;
  state_t r_state;
  logic [1:0] r_exp;
  logic [15:0] r_sh_dig, w_sh_dig;
  logic [3:0] r_sh_blk, w_sh_blk;
  logic w_end, w_legal, w_acc, w_ill, w_store;
  logic [1:0] w_idx, w_pos;
  logic [3:0] w_code;
  logic w_blank, w_bad, w_unused;

  seg7_to_bcd u_dec (
    .i_pat   (r_dat_q[6:0]),
    .o_code  (w_code),
    .o_blank (w_blank),
    .o_bad   (w_bad)
  );

  assign w_unused = r_dat_q[7];
  assign w_end = seg_sel != r_sel_q;
  assign w_legal = r_sel_q inside {SEL_D1, SEL_D2, SEL_D3, SEL_D4};
  assign w_idx = (r_sel_q == SEL_D2) ? 2'd1 : (r_sel_q == SEL_D3) ? 2'd2 :
                 (r_sel_q == SEL_D4) ? 2'd3 : 2'd0;
  assign w_pos = 2'd3 - w_idx;
  assign w_acc = w_end && w_legal && (r_dwell >= MIN_DWELL);
  assign w_ill = w_end && !w_legal && (r_sel_q != SEL_IDLE);
  // digit1 is always stored: it either starts a frame or restarts one
  assign w_store = w_acc && (w_idx == 2'd0 || (r_state == ST_RUN && w_idx == r_exp));

  always_comb begin
    w_sh_dig = r_sh_dig;
    w_sh_blk = r_sh_blk;
    w_sh_dig[{w_pos, 2'b00} +: 4] = w_code;
    w_sh_blk[w_pos] = w_blank;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_sel_q <= SEL_IDLE;
      r_dat_q <= 8'h00;
      r_dwell <= 16'd0;
      r_state <= ST_SYNC;
      r_exp <= 2'd0;
      r_sh_dig <= 16'h0000;
      r_sh_blk <= 4'h0;
      digits <= 16'h0000;
      blank <= 4'h0;
      frame_valid <= 1'b0;
      code_err <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      r_sel_q <= seg_sel;
      r_dat_q <= seg_dat;
      r_dwell <= w_end ? 16'd1 : (r_dwell >= MIN_DWELL) ? r_dwell : r_dwell + 16'd1;
      frame_valid <= 1'b0;
      seq_err <= 1'b0;
      code_err <= w_acc && w_bad;
      if (w_store) begin
        r_sh_dig <= w_sh_dig;
        r_sh_blk <= w_sh_blk;
      end
      if (w_ill) begin
        seq_err <= 1'b1;
        r_state <= ST_SYNC;
      end else if (w_acc) begin
        if (r_state == ST_SYNC) begin
          if (w_idx == 2'd0) begin
            r_state <= ST_RUN;
            r_exp <= 2'd1;
          end
        end else if (w_idx == r_exp) begin
          r_exp <= w_idx + 2'd1;
          if (w_idx == 2'd3) begin
            digits <= w_sh_dig;
            blank <= w_sh_blk;
            frame_valid <= 1'b1;
          end
        end else begin
          seq_err <= 1'b1;
          if (w_idx == 2'd0) r_exp <= 2'd1;
          else r_state <= ST_SYNC;
        end
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scans plus random scan traffic against a frame-level model
module tb_seg_scan_decoder;
  localparam logic [15:0] MD = 16'd4;
  logic clk = 1'b0;
  logic nRst = 1'b1;
  logic [3:0] seg_sel = 4'hF;
  logic [7:0] seg_dat = 8'h00;
  logic [15:0] digits;
  logic [3:0] blank;
  logic frame_valid, code_err, seq_err;
  int n_chk = 0, n_err = 0;

  logic [6:0] pat_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h67};
  logic [3:0] sel_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  logic [3:0] m_prev_sel;
  logic [7:0] m_prev_dat;
  int m_run, m_exp;
  bit m_sync;
  logic [3:0] m_sh [4];
  logic [3:0] m_dig [4];
  bit m_shb [4];
  bit m_blk [4];
  bit e_fv, e_ce, e_se;

  always #5 clk = ~clk;

  seg_scan_decoder #(.MIN_DWELL(MD)) dut (
    .clk         (clk),
    .nRst        (nRst),
    .seg_sel     (seg_sel),
    .seg_dat     (seg_dat),
    .digits      (digits),
    .blank       (blank),
    .frame_valid (frame_valid),
    .code_err    (code_err),
    .seq_err     (seq_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void decode(input logic [6:0] p, output logic [3:0] v, output bit b, output bit bad);
    v = 4'hE;
    b = 1'b0;
    bad = 1'b1;
    if (p == 7'h00) begin
      v = 4'hF;
      b = 1'b1;
      bad = 1'b0;
    end
    for (int i = 0; i < 10; i++)
      if (pat_tab[i] == p) begin
        v = 4'(i);
        bad = 1'b0;
      end
  endfunction

  task automatic model_reset();
    m_prev_sel = 4'hF;
    m_prev_dat = 8'h00;
    m_run = 0;
    m_exp = 0;
    m_sync = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_sh[i] = 4'h0;
      m_dig[i] = 4'h0;
      m_shb[i] = 1'b0;
      m_blk[i] = 1'b0;
    end
  endtask

  task automatic end_dwell();
    int k;
    logic [3:0] v;
    bit b, bad;
    k = -1;
    for (int i = 0; i < 4; i++) if (sel_tab[i] == m_prev_sel) k = i;
    if (k < 0) begin
      if (m_prev_sel != 4'hF) begin
        e_se = 1'b1;
        m_sync = 1'b1;
      end
    end else if (m_run >= int'(MD)) begin
      decode(m_prev_dat[6:0], v, b, bad);
      e_ce = bad;
      if (m_sync) begin
        if (k == 0) begin
          m_sh[0] = v; m_shb[0] = b; m_sync = 1'b0; m_exp = 1;
        end
      end else if (k == m_exp) begin
        m_sh[k] = v;
        m_shb[k] = b;
        m_exp = (k + 1) % 4;
        if (k == 3) begin
          m_dig = m_sh;
          m_blk = m_shb;
          e_fv = 1'b1;
        end
      end else begin
        e_se = 1'b1;
        if (k == 0) begin
          m_sh[0] = v; m_shb[0] = b; m_exp = 1;
        end else m_sync = 1'b1;
      end
    end
  endtask

  task automatic step(input logic [3:0] s, input logic [7:0] d);
    seg_sel = s;
    seg_dat = d;
    @(posedge clk);
    e_fv = 1'b0;
    e_ce = 1'b0;
    e_se = 1'b0;
    if (s != m_prev_sel) begin
      end_dwell();
      m_run = 1;
    end else m_run++;
    m_prev_sel = s;
    m_prev_dat = d;
    #1;
    chk("frame_valid", 32'(frame_valid), 32'(e_fv));
    chk("code_err", 32'(code_err), 32'(e_ce));
    chk("seq_err", 32'(seq_err), 32'(e_se));
    chk("digits", 32'(digits), 32'({m_dig[0], m_dig[1], m_dig[2], m_dig[3]}));
    chk("blank", 32'(blank), 32'({m_blk[0], m_blk[1], m_blk[2], m_blk[3]}));
  endtask

  task automatic apply_reset(input int hold);
    #2 nRst = 1'b0;
    #1;
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_blank", 32'(blank), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_ce", 32'(code_err), 32'h0);
    chk("rst_se", 32'(seq_err), 32'h0);
    model_reset();
    repeat (hold) @(posedge clk);
    #2 nRst = 1'b1;
  endtask

  task automatic seg(input int k, input logic [6:0] p, input int len);
    repeat (len) step(sel_tab[k], {1'b0, p});
  endtask

  task automatic scan(input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] p3,
                      input logic [6:0] p4, input int len);
    seg(0, p1, len);
    seg(1, p2, len);
    seg(2, p3, len);
    seg(3, p4, len);
  endtask

  initial begin
    logic [3:0] s;
    logic [6:0] p;
    int ptr, len, r, q;
    model_reset();
    #2;
    apply_reset(2);
    scan(7'h06, 7'h5B, 7'h4F, 7'h66, 6);
    scan(7'h06, 7'h5B, 7'h4F, 7'h66, 6);
    step(4'hF, 8'h00);
    chk("req028_digits", 32'(digits), 32'h1234);
    chk("req028_blank", 32'(blank), 32'h0);
    for (int i = 0; i < 4; i++) scan(7'h06, 7'h5B, (i % 2) ? 7'h00 : 7'h4F, 7'h66, 6);
    step(4'hF, 8'h00);
    chk("req029_digits", 32'(digits), 32'h12F4);
    chk("req029_blank", 32'(blank), 32'b0010);
    seg(0, 7'h06, 6);
    seg(1, 7'h5B, 2);
    seg(2, 7'h4F, 6);
    seg(3, 7'h66, 6);
    scan(7'h06, 7'h5B, 7'h4F, 7'h66, 6);
    step(4'hF, 8'h00);
    scan(7'h55, 7'h5B, 7'h4F, 7'h66, 6);
    step(4'hF, 8'h00);
    chk("req031_digits", 32'(digits), 32'hE234);
    seg(0, 7'h06, 6);
    seg(1, 7'h5B, 6);
    repeat (6) step(4'b0011, 8'h4F);
    seg(2, 7'h4F, 6);
    seg(3, 7'h66, 6);
    scan(7'h06, 7'h5B, 7'h4F, 7'h66, 6);
    step(4'hF, 8'h00);
    chk("req032_digits", 32'(digits), 32'h1234);
    scan(7'h3F, 7'h7F, 7'h07, 7'h6D, 6);
    step(4'hF, 8'h00);
    seg(0, 7'h06, 6);
    seg(1, 7'h5B, 6);
    seg(2, 7'h4F, 3);
    apply_reset(3);
    seg(2, 7'h4F, 6);
    seg(3, 7'h66, 6);
    scan(7'h06, 7'h5B, 7'h4F, 7'h66, 6);
    step(4'hF, 8'h00);
    chk("req033_digits", 32'(digits), 32'h1234);
    ptr = 0;
    for (int n = 0; n < 120; n++) begin
      if (n == 60) apply_reset(2);
      r = $urandom_range(0, 19);
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 7);
      if (r < 14) begin
        s = sel_tab[ptr];
        ptr = (ptr + 1) % 4;
      end else if (r < 16) begin
        s = 4'hF;
        len = $urandom_range(1, 3);
      end else if (r < 18) s = sel_tab[$urandom_range(0, 3)];
      else begin
        do s = 4'($urandom_range(0, 14)); while (s inside {4'b0111, 4'b1011, 4'b1101, 4'b1110});
        len = $urandom_range(4, 7);
      end
      q = $urandom_range(0, 11);
      p = (q < 10) ? pat_tab[q] : (q == 10) ? 7'h00 : 7'($urandom_range(0, 127));
      repeat (len) step(s, {1'($urandom_range(0, 1)), p});
    end
    step(4'hF, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
